// File: rtl/ofs_fim_eth_sb_tx_flow_ctrl_gen_if.sv
// Sideband TX flow-control generator bundle: request inputs and message/status outputs.
// master = requester side, slave = generator side.
interface ofs_fim_eth_sb_tx_flow_ctrl_gen_if #(
    parameter int unsigned NUM_PFC   = 8,
    parameter int unsigned SB_DATA_W = 16
);
    logic                 enable;
    logic                 req_pause;
    logic [NUM_PFC-1:0]   req_pfc;
    logic                 sb_tvalid;
    logic [SB_DATA_W-1:0] sb_tdata;
    logic [NUM_PFC:0]     pub_state;
    logic                 busy;
    logic [15:0]          tx_msg_cnt;

    modport master (
        output enable, req_pause, req_pfc,
        input  sb_tvalid, sb_tdata, pub_state, busy, tx_msg_cnt
    );

    modport slave (
        input  enable, req_pause, req_pfc,
        output sb_tvalid, sb_tdata, pub_state, busy, tx_msg_cnt
    );
endinterface

// File: rtl/ofs_fim_eth_sb_tx_flow_ctrl_gen.sv
// Turns level pause/PFC requests into spaced single-cycle sideband TX messages with XOFF refresh.
// Optional message counter enabled by defining OFS_FIM_ETH_SB_TX_MSG_CNT_EN.
module ofs_fim_eth_sb_tx_flow_ctrl_gen #(
    parameter int unsigned NUM_PFC   = 8,
    parameter int unsigned SB_DATA_W = 16,
    parameter int unsigned MIN_HOLD  = 16,
    parameter int unsigned REFRESH   = 1024
) (
    input logic clk,
    input logic rst_n,
    ofs_fim_eth_sb_tx_flow_ctrl_gen_if.slave sb
);

    localparam int unsigned VecW  = NUM_PFC + 1;
    localparam int unsigned HoldW = $clog2(MIN_HOLD);
    localparam int unsigned RefW  = $clog2(REFRESH);
    localparam logic [RefW-1:0]  RefMax   = RefW'(REFRESH - 1);
    localparam logic [HoldW-1:0] HoldLoad = HoldW'(MIN_HOLD - 2);

    typedef enum logic [1:0] {StIdle, StSend, StHold} state_e;

    state_e          state_q, state_d;
    logic [VecW-1:0] req_q;
    logic [VecW-1:0] snap_q, snap_d;
    logic [VecW-1:0] pub_q, pub_d;
    logic [HoldW-1:0] hold_q, hold_d;
    logic [RefW-1:0] ref_q, ref_d;
    logic            tvalid_q, tvalid_d;
    logic            ref_sat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            req_q    <= '0;
            snap_q   <= '0;
            pub_q    <= '0;
            hold_q   <= '0;
            ref_q    <= '0;
            tvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            req_q    <= {sb.req_pfc, sb.req_pause} & {VecW{sb.enable}};
            snap_q   <= snap_d;
            pub_q    <= pub_d;
            hold_q   <= hold_d;
            ref_q    <= ref_d;
            tvalid_q <= tvalid_d;
        end
    end

    assign ref_sat = (ref_q == RefMax);

    // The refresh counter restarts when SEND is entered, so refreshes repeat every REFRESH cycles.
    always_comb begin
        state_d  = state_q;
        snap_d   = snap_q;
        pub_d    = pub_q;
        hold_d   = hold_q;
        ref_d    = ref_q;
        tvalid_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (pub_q == '0) begin
                    ref_d = '0;
                end else if (!ref_sat) begin
                    ref_d = ref_q + 1'b1;
                end
                if ((req_q != pub_q) || ((pub_q != '0) && ref_sat)) begin
                    state_d  = StSend;
                    snap_d   = req_q;
                    tvalid_d = 1'b1;
                    ref_d    = '0;
                end
            end
            StSend: begin
                pub_d = snap_q;
                if (!ref_sat) begin
                    ref_d = ref_q + 1'b1;
                end
                if (MIN_HOLD > 2) begin
                    state_d = StHold;
                    hold_d  = HoldLoad;
                end else begin
                    state_d = StIdle;
                    hold_d  = '0;
                end
            end
            StHold: begin
                if (!ref_sat) begin
                    ref_d = ref_q + 1'b1;
                end
                hold_d = hold_q - 1'b1;
                if (hold_q <= HoldW'(1)) begin
                    state_d = StIdle;
                    hold_d  = '0;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        sb.sb_tdata           = '0;
        sb.sb_tdata[VecW-1:0] = snap_q;
    end

    assign sb.sb_tvalid = tvalid_q;
    assign sb.pub_state = pub_q;
    assign sb.busy      = (state_q != StIdle);

`ifdef OFS_FIM_ETH_SB_TX_MSG_CNT_EN
    logic [15:0] msg_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            msg_cnt_q <= '0;
        end else if ((state_q == StSend) && (msg_cnt_q != 16'hFFFF)) begin
            msg_cnt_q <= msg_cnt_q + 16'd1;
        end
    end

    assign sb.tx_msg_cnt = msg_cnt_q;
`else
    assign sb.tx_msg_cnt = 16'd0;
`endif

endmodule
